// File: rtl/hs_slice_chain_if.sv
// hs_slice_chain_if: one valid/ready/data channel between a master and a slave.
interface hs_slice_chain_if #(parameter int L = 8);
    logic         valid;
    logic         ready;
    logic [L-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/hs_slice_chain.sv
// hs_slice_chain: DEPTH valid/ready register slices in series, with flush and occupancy count.
// MODE 0 registers valid/data, MODE 1 registers ready (skid), MODE 2 does both per slice.
module hs_slice_chain #(
    parameter int L     = 8,
    parameter int DEPTH = 2,
    parameter int MODE  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    hs_slice_chain_if.slave                up,
    hs_slice_chain_if.master               dn,
    output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(2*DEPTH+1);

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("hs_slice_chain: MODE must be 0, 1 or 2");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("hs_slice_chain: DEPTH must be at least 1");
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        logic         uv, ur, dv, dr;
        logic [L-1:0] ud, dd;
        logic         mv, mr;
        logic [L-1:0] md;
        if (i == 0) begin : g_head
            assign uv       = up.valid;
            assign ud       = up.data;
            assign up.ready = ur;
        end else begin : g_link
            assign uv = g_slice[i-1].dv;
            assign ud = g_slice[i-1].dd;
        end
        if (i == DEPTH - 1) begin : g_tail
            assign dr = dn.ready;
        end else begin : g_next
            assign dr = g_slice[i+1].ur;
        end
        if (MODE != 1) begin : g_fwd
            logic         fv_q, fv_d;
            logic [L-1:0] fd_q, fd_d;
            assign ur = !fv_q || mr;
            assign mv = fv_q;
            assign md = fd_q;
            always_comb begin
                fv_d = flush ? 1'b0 : ur ? uv : fv_q;
                fd_d = flush ? '0 : (ur && uv) ? ud : fd_q;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    fv_q <= 1'b0;
                    fd_q <= '0;
                end else begin
                    fv_q <= fv_d;
                    fd_q <= fd_d;
                end
            end
        end else begin : g_fwd_thru
            assign ur = mr;
            assign mv = uv;
            assign md = ud;
        end
        if (MODE != 0) begin : g_skid
            logic         sv_q, sv_d;
            logic [L-1:0] sd_q, sd_d;
            // skid register catches the beat that arrives while downstream stalls
            assign mr = !sv_q;
            assign dv = mv || sv_q;
            assign dd = sv_q ? sd_q : md;
            always_comb begin
                sv_d = flush ? 1'b0 : (!dr && (mv || sv_q));
                sd_d = flush ? '0 : (mv && !sv_q && !dr) ? md : sd_q;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    sv_q <= 1'b0;
                    sd_q <= '0;
                end else begin
                    sv_q <= sv_d;
                    sd_q <= sd_d;
                end
            end
        end else begin : g_skid_thru
            assign mr = dr;
            assign dv = mv;
            assign dd = md;
        end
    end

    assign dn.valid = g_slice[DEPTH-1].dv;
    assign dn.data  = g_slice[DEPTH-1].dd;

    logic          push, pop;
    logic [OW-1:0] occ_q, occ_d;
    assign push = up.valid && up.ready;
    assign pop  = dn.valid && dn.ready;
    always_comb begin
        occ_d = flush ? '0 : occ_q + OW'(push) - OW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end
    assign occupancy = occ_q;
endmodule

// File: tb/tb_hs_slice_chain.sv
// tb_hs_slice_chain: three chain configurations checked against a FIFO model of accepted beats.
module tb_hs_slice_chain;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       vin [3], rin [3], fl [3], vout [3], rout [3];
    logic [7:0] din [3], dout [3];
    logic [2:0] occ [3];
    int total = 0, bad = 0;

    // instance 0: MODE2 DEPTH2, instance 1: MODE0 DEPTH2, instance 2: MODE1 DEPTH3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        hs_slice_chain_if #(.L(8)) up_if ();
        hs_slice_chain_if #(.L(8)) dn_if ();
        assign up_if.valid = vin[g];
        assign up_if.data  = din[g];
        assign rout[g]     = up_if.ready;
        assign vout[g]     = dn_if.valid;
        assign dout[g]     = dn_if.data;
        assign dn_if.ready = rin[g];
        hs_slice_chain #(.L(8), .DEPTH(g == 2 ? 3 : 2), .MODE(g == 0 ? 2 : (g == 1 ? 0 : 1))) u_dut (
            .clk(clk), .rst(rst), .flush(fl[g]), .up(up_if), .dn(dn_if), .occupancy(occ[g])
        );
    end

    function automatic int mode_of(int k);
        return k == 0 ? 2 : (k == 1 ? 0 : 1);
    endfunction
    function automatic int cap_of(int k);
        return k == 0 ? 4 : (k == 1 ? 2 : 3);
    endfunction

    logic [7:0] mem [3][64];
    int hd [3], tl [3], seq [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic push [3], pop [3];
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int cnt = tl[k] - hd[k];
            int m = mode_of(k);
            push[k] = vin[k] && rout[k];
            pop[k]  = vout[k] && rin[k];
            if (!rst) begin
                check($sformatf("occ%0d", k), 32'(occ[k]), cnt);
                if (cnt == 0) begin
                    check($sformatf("empty_v%0d", k), 32'(vout[k]), m == 1 ? 32'(vin[k]) : 0);
                    check($sformatf("empty_r%0d", k), 32'(rout[k]), 1);
                end
                if (m == 0) check($sformatf("rdy%0d", k), 32'(rout[k]), 32'((cnt < cap_of(k)) || rin[k]));
                else if (cnt == cap_of(k)) check($sformatf("full_r%0d", k), 32'(rout[k]), 0);
                if (vout[k]) check($sformatf("data%0d", k), 32'(dout[k]), cnt > 0 ? 32'(mem[k][hd[k] % 64]) : 32'(din[k]));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rst || fl[k]) hd[k] = tl[k];
            else begin
                if (push[k]) begin
                    mem[k][tl[k] % 64] = din[k];
                    tl[k]++;
                end
                if (pop[k]) hd[k]++;
            end
        end
    endtask

    initial begin
        int acc;
        logic accd [3];
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b1; din[k] = 8'h77; rin[k] = 1'b1; fl[k] = 1'b0;
            hd[k] = 0; tl[k] = 0; seq[k] = 0;
        end
        cycle();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) vin[k] = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_v%0d", k), 32'(vout[k]), 0);
            check($sformatf("rst_occ%0d", k), 32'(occ[k]), 0);
            check($sformatf("rst_r%0d", k), 32'(rout[k]), 1);
        end
        cycle();
        // streaming through MODE2 DEPTH2
        for (int j = 0; j < 18; j++) begin
            vin[0] = (j < 16); din[0] = 8'(j + 1); rin[0] = 1'b1;
            #1;
            if (j < 16) check("s_rdy", 32'(rout[0]), 1);
            if (j >= 2) begin
                check("s_v", 32'(vout[0]), 1);
                check("s_d", 32'(dout[0]), j - 1);
            end else check("s_lat", 32'(vout[0]), 0);
            cycle();
        end
        vin[0] = 1'b0;
        cycle();
        // backpressure fills MODE2 DEPTH2 to four beats
        rin[0] = 1'b0; vin[0] = 1'b1; acc = 0;
        for (int j = 0; j < 8; j++) begin
            din[0] = 8'(8'hA0 + acc);
            #1;
            if (rout[0]) acc++;
            cycle();
        end
        vin[0] = 1'b0;
        #1;
        check("bp_acc", acc, 4);
        check("bp_r", 32'(rout[0]), 0);
        check("bp_occ", 32'(occ[0]), 4);
        rin[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("bp_v", 32'(vout[0]), 1);
            check("bp_d", 32'(dout[0]), 8'hA0 + j);
            cycle();
        end
        #1;
        check("bp_empty", 32'(vout[0]), 0);
        // MODE0 full chain keeps accepting while popping
        rin[1] = 1'b0; vin[1] = 1'b1; acc = 0;
        for (int j = 0; j < 4; j++) begin
            din[1] = 8'(8'hB0 + acc);
            #1;
            if (rout[1]) acc++;
            cycle();
        end
        din[1] = 8'(8'hB0 + acc);
        #1;
        check("m0_occ", 32'(occ[1]), 2);
        check("m0_full_r", 32'(rout[1]), 0);
        rin[1] = 1'b1;
        #1;
        check("m0_pp_r", 32'(rout[1]), 1);
        check("m0_pp_d0", 32'(dout[1]), 8'hB0);
        cycle();
        vin[1] = 1'b0;
        #1;
        check("m0_pp_occ", 32'(occ[1]), 2);
        check("m0_pp_d1", 32'(dout[1]), 8'hB1);
        repeat (3) cycle();
        // flush with three beats held
        rin[0] = 1'b0; vin[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din[0] = 8'(8'hC0 + j);
            cycle();
        end
        din[0] = 8'hC3;
        #1;
        check("fl_occ3", 32'(occ[0]), 3);
        fl[0] = 1'b1;
        cycle();
        fl[0] = 1'b0; vin[0] = 1'b0; rin[0] = 1'b1;
        #1;
        check("fl_v", 32'(vout[0]), 0);
        check("fl_occ", 32'(occ[0]), 0);
        for (int j = 0; j < 5; j++) begin
            cycle();
            check("fl_gone", 32'(vout[0]), 0);
        end
        // MODE1 DEPTH3 zero latency then fill
        vin[2] = 1'b1; din[2] = 8'h5A; rin[2] = 1'b1;
        #1;
        check("m1_v", 32'(vout[2]), 1);
        check("m1_d", 32'(dout[2]), 8'h5A);
        cycle();
        rin[2] = 1'b0; acc = 0;
        for (int j = 0; j < 5; j++) begin
            din[2] = 8'(8'h60 + acc);
            #1;
            if (rout[2]) acc++;
            cycle();
        end
        vin[2] = 1'b0;
        #1;
        check("m1_acc", acc, 3);
        check("m1_r", 32'(rout[2]), 0);
        check("m1_occ", 32'(occ[2]), 3);
        rin[2] = 1'b1;
        repeat (5) cycle();
        // random traffic on all three chains
        for (int k = 0; k < 3; k++) accd[k] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < 3; k++) begin
                if (!vin[k] || accd[k]) begin
                    vin[k] = ($urandom_range(0, 9) < 7);
                    din[k] = 8'(seq[k]);
                    seq[k]++;
                end
                rin[k] = ($urandom_range(0, 9) < 6);
                fl[k]  = ($urandom_range(0, 59) == 0);
            end
            #1;
            for (int k = 0; k < 3; k++) accd[k] = (vin[k] && rout[k]) || fl[k] || rst;
            cycle();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0; rin[k] = 1'b1; fl[k] = 1'b0;
        end
        repeat (12) cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain%0d", k), tl[k] - hd[k], 0);
            check($sformatf("drain_occ%0d", k), 32'(occ[k]), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
